// File: rtl/bcd_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg: shared types and constants for the serial BCD adder family.
//   state_t  : controller state (IDLE, RUN, DONE), also exported for debug
//   DIGIT_W  : bits per BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   BCD_BASE : decimal radix, used by the >9 correction
//   is_bcd() : true when a 4-bit digit is a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_BASE = 4'd10;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder_if: operand/result bundle between the operand capture
// logic (master) and the serial BCD adder (slave).
//   start, sub, cin, a, b : request side, driven by the master
//   sum, cout, busy, done, error : result side, driven by the adder
//
// Handshake: the master raises start with a, b, sub, cin valid; the adder
// accepts it on any rising edge where it is not busy (IDLE or DONE). busy is
// high while digits are processed and any start seen then is ignored. done
// pulses for one cycle when sum/cout are valid; sum/cout stay stable until
// the next accepted start. error is valid from the cycle after acceptance.
// ---------------------------------------------------------------------------
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, sub, cin, a, b,
    input  sum, cout, busy, done, error
  );

  modport slave (
    input  start, sub, cin, a, b,
    output sum, cout, busy, done, error
  );
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add: combinational single-digit BCD add / nine's-complement add.
//   i_x, i_y  : 4-bit BCD digits (i_y is complemented when i_sub=1)
//   i_cin     : decimal carry in
//   i_sub     : 1 = use (9 - i_y) mod 16 in place of i_y
//   o_digit   : corrected BCD result digit
//   o_cout    : decimal carry out (raw sum > 9)
//   o_invalid : either input digit is > 9
// ---------------------------------------------------------------------------
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_cin,
  input  logic       i_sub,
  output logic [3:0] o_digit,
  output logic       o_cout,
  output logic       o_invalid
);

  logic [3:0] w_yd;
  logic [4:0] w_raw;
  logic [3:0] w_adj;

  // 4-bit subtraction wraps mod 16, which gives the defined result for
  // non-BCD y digits as well.
  assign w_yd  = i_sub ? (BCD_MAX - i_y) : i_y;
  assign w_raw = {1'b0, i_x} + {1'b0, w_yd} + {4'b0000, i_cin};
  // Only the low nibble of (raw - 10) is kept, so the low nibble of raw is
  // enough to compute it.
  assign w_adj = w_raw[3:0] - BCD_BASE;

  assign o_cout    = (w_raw > {1'b0, BCD_MAX});
  assign o_digit   = o_cout ? w_adj : w_raw[3:0];
  assign o_invalid = !is_bcd(i_x) || !is_bcd(i_y);

endmodule

// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder: multi-digit BCD adder/subtractor, one digit per clock,
// least-significant digit first.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : start/sub/cin/a/b request, sum/cout/busy/done/error result
//   o_dbg_state : current controller state, for observation only
// Timing: start accepted at edge 0, digit k-1 processed at edge k
// (k = 1..DIGITS), done high in the cycle after edge DIGITS.
// ---------------------------------------------------------------------------
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_adder_if.slave    bus,
  output state_t               o_dbg_state
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;
  logic               w_op_invalid;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_sub;
  logic               r_carry;
  logic               r_cout;
  logic               r_error;
  logic [IDX_W-1:0]   r_idx;

  logic [3:0]         w_x;
  logic [3:0]         w_y;
  logic [3:0]         w_digit;
  logic               w_carry_out;
  logic               w_digit_invalid;

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end
      end
      RUN: begin
        if (r_idx == IDX_W'(DIGITS - 1)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand check is done on the unlatched inputs so error is valid in the
  // first RUN cycle, before any digit has been processed.
  always_comb begin
    w_op_invalid = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (!is_bcd(bus.a[d*DIGIT_W +: DIGIT_W]) ||
          !is_bcd(bus.b[d*DIGIT_W +: DIGIT_W])) begin
        w_op_invalid = 1'b1;
      end
    end
  end

  // ---------------- datapath ----------------
  assign w_x = r_a[r_idx*DIGIT_W +: DIGIT_W];
  assign w_y = r_b[r_idx*DIGIT_W +: DIGIT_W];

  bcd_digit_add u_digit_add (
    .i_x       (w_x),
    .i_y       (w_y),
    .i_cin     (r_carry),
    .i_sub     (r_sub),
    .o_digit   (w_digit),
    .o_cout    (w_carry_out),
    .o_invalid (w_digit_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sub   <= bus.sub;
      // Subtraction is a + nines(b) + 1, so the +1 enters as the carry.
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_error <= w_op_invalid;
    end else if (r_state == RUN) begin
      r_sum[r_idx*DIGIT_W +: DIGIT_W] <= w_digit;
      r_carry <= w_carry_out;
      // Already set at acceptance for any bad digit; the per-digit flag
      // keeps it sticky should operands ever be loaded another way.
      r_error <= r_error | w_digit_invalid;
      if (w_last) r_cout <= w_carry_out;
      else        r_idx  <= r_idx + IDX_W'(1);
    end
  end

  // ---------------- outputs ----------------
  assign bus.sum    = r_sum;
  assign bus.cout   = r_cout;
  assign bus.busy   = (r_state == RUN);
  assign bus.done   = (r_state == DONE);
  assign bus.error  = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     failures;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint bcd_to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + longint'(v[d*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input longint x);
    logic [W-1:0] r = '0;
    longint       t = x;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    for (int d = 0; d < DIGITS; d++) if (v[d*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Decimal arithmetic: a + b + cin, or a - b taken modulo 10^DIGITS.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin,
                       output logic [W-1:0] sum, output logic cout);
    longint m = 1;
    longint s;
    for (int d = 0; d < DIGITS; d++) m = m * 10;
    if (sub) s = bcd_to_int(a) - bcd_to_int(b) + m;
    else     s = bcd_to_int(a) + bcd_to_int(b) + longint'(cin);
    cout = (s >= m);
    sum  = int_to_bcd(s % m);
  endtask

  // ---------------- drivers ----------------
  // Presents an operation and returns at the falling edge after acceptance.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts falling edges until done, bounded; also counts busy samples.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         chk_sum;
  } vec_t;

  vec_t         vecs[9];
  logic [W:0]   exp_q[$];

  initial begin
    int           n, bc;
    logic [W-1:0] ra, rb, esum, held;
    logic         rsub, rcin, ecout, eerr, saw_done;
    logic [W:0]   exp_e;

    checks = 0; failures = 0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sum",   32'(bus.sum), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_done",  32'(bus.done), 32'h0);
    check("rst_error", 32'(bus.error), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // ---- table-driven vectors ----
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0009, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0500, 16'h0500, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      check($sformatf("v%0d_err_start", i), 32'(bus.error), 32'(vecs[i].err));
      check($sformatf("v%0d_sum_cleared", i), 32'(bus.sum), 32'h0);
      wait_done(n, bc);
      check($sformatf("v%0d_done_seen", i), 32'(bus.done), 32'h1);
      check($sformatf("v%0d_latency", i), 32'(n), 32'(DIGITS));
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(DIGITS));
      check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'h0);
      if (vecs[i].chk_sum) begin
        check($sformatf("v%0d_sum", i), 32'(bus.sum), 32'(vecs[i].sum));
        check($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
      end
      check($sformatf("v%0d_err_done", i), 32'(bus.error), 32'(vecs[i].err));
      held = bus.sum;
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'h0);
      check($sformatf("v%0d_sum_held", i), 32'(bus.sum), 32'(held));
      check($sformatf("v%0d_err_held", i), 32'(bus.error), 32'(vecs[i].err));
      check($sformatf("v%0d_idle", i), 32'(dbg_state), 32'(IDLE));
    end

    // ---- start during RUN is ignored ----
    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 16'h9999; bus.b = 16'h9999; bus.sub = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, bc);
    check("ign_done_seen", 32'(bus.done), 32'h1);
    check("ign_sum", 32'(bus.sum), 32'h6912);
    check("ign_cout", 32'(bus.cout), 32'h0);

    // ---- back-to-back: start present while in DONE ----
    @(negedge clk);
    launch(16'h0500, 16'h0123, 1'b1, 1'b0);
    wait_done(n, bc);
    check("b2b_first_sum", 32'(bus.sum), 32'h0377);
    bus.a = 16'h0001; bus.b = 16'h0002; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_idle_busy", 32'(bus.busy), 32'h1);
    check("b2b_no_idle_state", 32'(dbg_state), 32'(RUN));
    wait_done(n, bc);
    check("b2b_latency", 32'(n), 32'(DIGITS));
    check("b2b_second_sum", 32'(bus.sum), 32'h0003);

    // ---- reset in the middle of an operation ----
    @(negedge clk);
    launch(16'h12A4, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_err_before", 32'(bus.error), 32'h1);
    check("mid_partial_sum", 32'(bus.sum), 32'h0004);
    rst = 1'b1;
    #1;
    check("mid_rst_sum",   32'(bus.sum), 32'h0);
    check("mid_rst_busy",  32'(bus.busy), 32'h0);
    check("mid_rst_done",  32'(bus.done), 32'h0);
    check("mid_rst_cout",  32'(bus.cout), 32'h0);
    check("mid_rst_error", 32'(bus.error), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (DIGITS + 3) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("mid_no_done", 32'(saw_done), 32'h0);

    // ---- randomized operations against the decimal model ----
    for (int t = 0; t < 40; t++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
      rsub = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      eerr = has_bad(ra) | has_bad(rb);
      model(ra, rb, rsub, rcin, esum, ecout);
      exp_q.push_back({ecout, esum});
      launch(ra, rb, rsub, rcin);
      wait_done(n, bc);
      check($sformatf("r%0d_done_seen", t), 32'(bus.done), 32'h1);
      check($sformatf("r%0d_error", t), 32'(bus.error), 32'(eerr));
      exp_e = exp_q.pop_front();
      if (!eerr) begin
        check($sformatf("r%0d_sum", t), 32'(bus.sum), 32'(exp_e[W-1:0]));
        check($sformatf("r%0d_cout", t), 32'(bus.cout), 32'(exp_e[W]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
